// File: rtl/ctrl_seq_pkg.sv
// Shared constants, state encoding and phase masks for the control sequencer.
// The base control-word field layout is also defined here so the ROM stays a pure lookup.
package ctrl_seq_pkg;

  localparam int LOADI_LOADP = 6;
  localparam int ADD         = 7;
  localparam int STORE       = 13;
  localparam int BRE_BRZ     = 19;
  localparam int BRNE_BRNZ   = 20;
  localparam int BRG         = 21;
  localparam int BRGE        = 22;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MEM  = 2'd2,
    S_WB   = 2'd3
  } state_t;

  // Control word layout: [17:12] writeback fields, [11:6] memory fields, [5:0] execute fields
  localparam logic [17:0] EXEC_MASK = 18'h0003F;
  localparam logic [17:0] MEM_MASK  = 18'h00FC0;
  localparam logic [17:0] WB_MASK   = 18'h3F000;

  localparam logic [26:0] MEM_OPS = (27'd1 << LOADI_LOADP) | (27'd1 << STORE);
  localparam logic [26:0] WB_OPS  = 27'h0001FC0;

  function automatic logic [17:0] rom_entry(input int idx);
    logic [5:0]  ex, mm, wb;
    logic [26:0] m_sh, w_sh;
    ex   = 6'(idx + 1);
    mm   = '0;
    wb   = '0;
    m_sh = MEM_OPS >> idx;
    w_sh = WB_OPS >> idx;
    if (m_sh[0]) mm = 6'h20 | 6'(idx);
    if (w_sh[0]) wb = 6'h30 | 6'(idx);
    return {wb, mm, ex};
  endfunction

endpackage

// File: rtl/ctrl_rom.sv
// Combinational decoder table: one-hot opcode to unmasked base control word.
module ctrl_rom
  import ctrl_seq_pkg::*;
#(
  parameter int NUM_OPS = 27,
  parameter int CTRL_W  = 18
) (
  input  logic [NUM_OPS-1:0] opcode,
  output logic [CTRL_W-1:0]  word
);

  logic [NUM_OPS-1:0] op_sh;

  always_comb begin
    word  = '0;
    op_sh = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      op_sh = opcode >> i;
      if (op_sh[0]) word = word | CTRL_W'(rom_entry(i));
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: accepts a one-hot opcode and walks it through EXEC/MEM/WB,
// driving a phase-masked control word, resolving branches and timing out stalled memory.
module control_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int NUM_OPS = 27,
  parameter int CTRL_W  = 18,
  parameter int FLAG_W  = 4,
  parameter int BR_BASE = 19,
  parameter int MEM_TO  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [NUM_OPS-1:0] opcode_in,
  input  logic [FLAG_W-1:0]  break_flag,
  input  logic               mem_ready,
  output logic [CTRL_W-1:0]  control,
  output logic [1:0]         phase,
  output logic               pc_load,
  output logic               retire,
  output logic               illegal_op,
  output logic               mem_err
);

  localparam int                 CNT_W   = $clog2(MEM_TO + 1);
  localparam logic [NUM_OPS-1:0] MEM_SET = NUM_OPS'(MEM_OPS);
  localparam logic [NUM_OPS-1:0] WB_SET  = NUM_OPS'(WB_OPS);
  localparam logic [CTRL_W-1:0]  EXEC_M  = CTRL_W'(EXEC_MASK);
  localparam logic [CTRL_W-1:0]  MEM_M   = CTRL_W'(MEM_MASK);
  localparam logic [CTRL_W-1:0]  WB_M    = CTRL_W'(WB_MASK);

  state_t             state, state_nx;
  logic [NUM_OPS-1:0] op_q, op_sh;
  logic [FLAG_W-1:0]  flag_q, fl_sh;
  logic [CNT_W-1:0]   cnt;
  logic               ill_q;
  logic               accept, onehot_in;
  logic               is_branch, taken, has_mem, has_wb;
  logic [CTRL_W-1:0]  rom_word;

  // instr_ready is gated by rst so nothing is offered while the block is held in reset
  assign instr_ready = (state == S_IDLE) && !rst;
  assign accept      = instr_valid && instr_ready;
  assign onehot_in   = (opcode_in != '0) && ((opcode_in & (opcode_in - 1'b1)) == '0);
  assign has_mem     = |(op_q & MEM_SET);
  assign has_wb      = |(op_q & WB_SET);
  assign phase       = state;
  assign illegal_op  = ill_q;

  ctrl_rom #(.NUM_OPS(NUM_OPS), .CTRL_W(CTRL_W)) u_rom (
    .opcode (op_q),
    .word   (rom_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= '0;
      flag_q <= '0;
      cnt    <= '0;
      ill_q  <= 1'b0;
    end else begin
      state <= state_nx;
      ill_q <= accept && !onehot_in;
      if (accept) begin
        op_q   <= opcode_in;
        flag_q <= break_flag;
      end
      if (state == S_MEM && state_nx == S_MEM) cnt <= cnt + 1'b1;
      else                                     cnt <= '0;
    end
  end

  // Branch op BR_BASE+k tests the flag counted down from the MSB
  always_comb begin
    is_branch = 1'b0;
    taken     = 1'b0;
    op_sh     = '0;
    fl_sh     = '0;
    for (int k = 0; k < FLAG_W; k++) begin
      op_sh = op_q >> (BR_BASE + k);
      fl_sh = flag_q >> (FLAG_W - 1 - k);
      if (op_sh[0]) begin
        is_branch = 1'b1;
        taken     = fl_sh[0];
      end
    end
  end

  // In MEM, retire/mem_err follow mem_ready in the same cycle; mem_ready wins on the last cycle
  always_comb begin
    state_nx = state;
    control  = '0;
    pc_load  = 1'b0;
    retire   = 1'b0;
    mem_err  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nx = onehot_in ? S_EXEC : S_IDLE;
      end
      S_EXEC: begin
        control = rom_word & EXEC_M;
        if (is_branch) begin
          pc_load  = taken;
          retire   = 1'b1;
          state_nx = S_IDLE;
        end else if (has_mem) begin
          state_nx = S_MEM;
        end else if (has_wb) begin
          state_nx = S_WB;
        end else begin
          retire   = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_MEM: begin
        control = rom_word & MEM_M;
        if (mem_ready) begin
          if (has_wb) begin
            state_nx = S_WB;
          end else begin
            retire   = 1'b1;
            state_nx = S_IDLE;
          end
        end else if (cnt == CNT_W'(MEM_TO - 1)) begin
          control  = '0;
          mem_err  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_WB: begin
        control  = rom_word & WB_M;
        retire   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
